// File: rtl/gated_sr_pkg.sv
// Shared types and the per-lane truth table for the gated SR latch.
package gated_sr_pkg;

   // What a lane does when enable, set and reset are all high together.
   typedef enum logic [1:0] {
      HOLD      = 2'd0,
      RESET_DOM = 2'd1,
      SET_DOM   = 2'd2
   } both_mode_e;

   // Next stored value of one lane given its current value and sampled inputs.
   function automatic logic next_q(input logic q,
                                   input logic e,
                                   input logic s,
                                   input logic r,
                                   input both_mode_e mode);
      logic nq;
      nq = q;
      if (e) begin
         case ({s, r})
            2'b10:   nq = 1'b1;
            2'b01:   nq = 1'b0;
            2'b11: begin
               case (mode)
                  RESET_DOM: nq = 1'b0;
                  SET_DOM:   nq = 1'b1;
                  default:   nq = q;
               endcase
            end
            default: nq = q;
         endcase
      end
      return nq;
   endfunction

   // The forbidden combination: gate open with both requests asserted.
   function automatic logic is_forbidden(input logic e,
                                         input logic s,
                                         input logic r);
      return e & s & r;
   endfunction

endpackage

// File: rtl/gated_sr_latch_sync_if.sv
// Request/response bundle of the gated SR latch, one bit per lane.
interface gated_sr_latch_sync_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] E;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] R;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qbar;
   logic [WIDTH-1:0] illegal;

   // The driver of the requests.
   modport master (output E, S, R, input Q, Qbar, illegal);
   // The latch itself.
   modport slave  (input E, S, R, output Q, Qbar, illegal);
endinterface

// File: rtl/sr_lane_cell.sv
// One lane of the gated SR latch: a stored bit and a registered forbidden-input flag.
module sr_lane_cell
   import gated_sr_pkg::*;
#(
   parameter both_mode_e BOTH_MODE = HOLD,
   parameter logic       RESET_Q   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_e,
   input  logic i_s,
   input  logic i_r,
   output logic o_q,
   output logic o_illegal
);

   logic r_q;
   logic r_illegal;

   // Update the stored bit and the forbidden flag on every rising edge; reset wins.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // and the reset sits inside the clocked branch, making it synchronous.
      if (rst) begin
         r_q       <= RESET_Q;
         r_illegal <= 1'b0;
      end else begin
         r_q       <= next_q(r_q, i_e, i_s, i_r, BOTH_MODE);
         r_illegal <= is_forbidden(i_e, i_s, i_r);
      end
   end

   assign o_q       = r_q;
   assign o_illegal = r_illegal;

endmodule

// File: rtl/gated_sr_latch_sync.sv
// Clock-synchronous gated SR latch, WIDTH independent lanes with Qbar = ~Q.
module gated_sr_latch_sync
   import gated_sr_pkg::*;
#(
   parameter int         WIDTH     = 1,
   parameter both_mode_e BOTH_MODE = HOLD,
   parameter logic       RESET_Q   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   gated_sr_latch_sync_if.slave  bus
);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_illegal;

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      sr_lane_cell #(
         .BOTH_MODE (BOTH_MODE),
         .RESET_Q   (RESET_Q)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .i_e       (bus.E[g]),
         .i_s       (bus.S[g]),
         .i_r       (bus.R[g]),
         .o_q       (w_q[g]),
         .o_illegal (w_illegal[g])
      );
   end

   // Qbar is derived from the flop, so it can never disagree with Q.
   assign bus.Q       = w_q;
   assign bus.Qbar    = ~w_q;
   assign bus.illegal = w_illegal;

endmodule

// File: tb/tb_gated_sr_latch_sync.sv
// Self-checking bench: three 4-lane latches (one per BOTH_MODE) share stimulus
// and are compared every cycle against a mask-based model.
module tb_gated_sr_latch_sync;
   import gated_sr_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   logic [W-1:0] e, s, r;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gated_sr_latch_sync_if #(.WIDTH(W)) if_h ();
   gated_sr_latch_sync_if #(.WIDTH(W)) if_r ();
   gated_sr_latch_sync_if #(.WIDTH(W)) if_s ();

   assign if_h.E = e;  assign if_h.S = s;  assign if_h.R = r;
   assign if_r.E = e;  assign if_r.S = s;  assign if_r.R = r;
   assign if_s.E = e;  assign if_s.S = s;  assign if_s.R = r;

   gated_sr_latch_sync #(.WIDTH(W), .BOTH_MODE(HOLD),      .RESET_Q(1'b0))
      u_hold (.clk(clk), .rst(rst), .bus(if_h));
   gated_sr_latch_sync #(.WIDTH(W), .BOTH_MODE(RESET_DOM), .RESET_Q(1'b0))
      u_rdom (.clk(clk), .rst(rst), .bus(if_r));
   gated_sr_latch_sync #(.WIDTH(W), .BOTH_MODE(SET_DOM),   .RESET_Q(1'b0))
      u_sdom (.clk(clk), .rst(rst), .bus(if_s));

   // DUT outputs indexed by mode: 0 = HOLD, 1 = RESET_DOM, 2 = SET_DOM.
   logic [W-1:0] dq[3], dqb[3], dill[3];
   assign dq[0] = if_h.Q;  assign dqb[0] = if_h.Qbar;  assign dill[0] = if_h.illegal;
   assign dq[1] = if_r.Q;  assign dqb[1] = if_r.Qbar;  assign dill[1] = if_r.illegal;
   assign dq[2] = if_s.Q;  assign dqb[2] = if_s.Qbar;  assign dill[2] = if_s.illegal;

   // Reference model state.
   logic [W-1:0] exp_q[3];
   logic [W-1:0] exp_ill[3];
   bit model_valid = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
      end
   endtask

   // Model: whole-vector mask arithmetic evaluated at each rising edge.
   always @(posedge clk) begin
      logic [W-1:0] set_m, clr_m, both_m, nq;
      set_m  = e & s & ~r;
      clr_m  = e & r & ~s;
      both_m = e & s & r;
      for (int m = 0; m < 3; m++) begin
         if (rst) begin
            exp_q[m]   = '0;
            exp_ill[m] = '0;
         end else begin
            nq = (exp_q[m] | set_m) & ~clr_m;
            if (m == 1)      nq = nq & ~both_m;
            else if (m == 2) nq = nq | both_m;
            exp_q[m]   = nq;
            exp_ill[m] = both_m;
         end
      end
      if (rst) model_valid = 1'b1;
   end

   // Compare every DUT against the model half a cycle after each edge.
   always @(negedge clk) begin
      if (model_valid) begin
         for (int m = 0; m < 3; m++) begin
            check($sformatf("cyc_q_m%0d", m),    dq[m],   exp_q[m]);
            check($sformatf("cyc_qbar_m%0d", m), dqb[m],  ~exp_q[m]);
            check($sformatf("cyc_ill_m%0d", m),  dill[m], exp_ill[m]);
         end
      end
   end

   task automatic drive(input logic rst_v, input logic [W-1:0] e_v,
                        input logic [W-1:0] s_v, input logic [W-1:0] r_v);
      rst = rst_v;
      e   = e_v;
      s   = s_v;
      r   = r_v;
   endtask

   // Advance past one rising edge; returns just after the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input logic [W-1:0] q0,
                            input logic [W-1:0] q1, input logic [W-1:0] q2,
                            input logic [W-1:0] ill);
      logic [W-1:0] qs[3];
      qs[0] = q0; qs[1] = q1; qs[2] = q2;
      for (int m = 0; m < 3; m++) begin
         check($sformatf("%s_q_m%0d", name, m),    dq[m],   qs[m]);
         check($sformatf("%s_qbar_m%0d", name, m), dqb[m],  ~qs[m]);
         check($sformatf("%s_ill_m%0d", name, m),  dill[m], ill);
      end
   endtask

   initial begin
      drive(1'b1, 4'h0, 4'h0, 4'h0);
      tick();
      tick();
      check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);

      // Per-lane set on lanes 1 and 3.
      drive(1'b0, 4'hF, 4'b1010, 4'h0);
      tick();
      check_all("set", 4'b1010, 4'b1010, 4'b1010, 4'h0);

      // Gate closed: requests ignored.
      drive(1'b0, 4'h0, 4'h0, 4'hF);
      tick();
      tick();
      drive(1'b0, 4'h0, 4'hF, 4'h0);
      tick();
      check_all("hold_closed", 4'b1010, 4'b1010, 4'b1010, 4'h0);

      // Reset while enabled, then closed-gate requests including S=R=1.
      drive(1'b0, 4'hF, 4'h0, 4'hF);
      tick();
      check_all("clear", 4'h0, 4'h0, 4'h0, 4'h0);
      drive(1'b0, 4'h0, 4'hF, 4'hF);
      tick();
      drive(1'b0, 4'h0, 4'hF, 4'h0);
      tick();
      check_all("hold_zero", 4'h0, 4'h0, 4'h0, 4'h0);

      // Forbidden input from Q=1.
      drive(1'b0, 4'hF, 4'hF, 4'h0);
      tick();
      drive(1'b0, 4'hF, 4'hF, 4'hF);
      tick();
      check_all("forbid_q1", 4'hF, 4'h0, 4'hF, 4'hF);
      drive(1'b0, 4'h0, 4'h0, 4'h0);
      tick();
      check_all("forbid_q1_after", 4'hF, 4'h0, 4'hF, 4'h0);

      // Forbidden input from Q=0, on lanes 0 and 2 only.
      drive(1'b0, 4'hF, 4'h0, 4'hF);
      tick();
      drive(1'b0, 4'b0101, 4'hF, 4'hF);
      tick();
      check_all("forbid_q0", 4'h0, 4'h0, 4'b0101, 4'b0101);

      // A set pulse that starts and ends between edges is invisible.
      drive(1'b0, 4'hF, 4'h0, 4'hF);
      tick();
      drive(1'b0, 4'hF, 4'h0, 4'h0);
      tick();
      s = 4'hF;
      #2;
      s = 4'h0;
      tick();
      check_all("glitch", 4'h0, 4'h0, 4'h0, 4'h0);

      // Reset priority: from 4'b1010, reset with a full set pending.
      drive(1'b0, 4'hF, 4'b1010, 4'b0101);
      tick();
      check_all("pre_rst", 4'b1010, 4'b1010, 4'b1010, 4'h0);
      drive(1'b1, 4'hF, 4'hF, 4'h0);
      tick();
      check_all("rst_prio", 4'h0, 4'h0, 4'h0, 4'h0);
      drive(1'b0, 4'hF, 4'hF, 4'h0);
      tick();
      check_all("post_rst_set", 4'hF, 4'hF, 4'hF, 4'h0);

      // Randomized traffic, occasional reset; the compare process checks each cycle.
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 19) == 0), W'($urandom), W'($urandom), W'($urandom));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gated_sr_latch_sync.md
Name: gated_sr_latch_sync

Overview:
- Clock-synchronous model of a gated (enable-controlled) SR latch, replicated per bit lane.
- While enable E is high, S sets and R resets the stored bit. While E is low, the stored value holds regardless of S/R.
- Used as a small state-holding primitive in digital-logic lab designs. Fully synchronous to clk so it is FPGA-safe (no combinational loops).

Parameters:
- WIDTH, 1, number of independent SR lanes; S, R, E, Q, Qbar are each WIDTH bits.
- BOTH_MODE, HOLD, action when E=S=R=1 on a lane: HOLD keeps state, RESET_DOM forces 0, SET_DOM forces 1.
- RESET_Q, 1'b0, value of every Q lane after reset; Qbar takes the complement.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- E  input  WIDTH  per-lane enable (gate).
- S  input  WIDTH  per-lane set request.
- R  input  WIDTH  per-lane reset request.
- Q  output  WIDTH  stored value.
- Qbar  output  WIDTH  complement of Q.
- illegal  output  WIDTH  per-lane flag for forbidden input; registered.

Behaviour:
- Reset: on a rising clk edge with rst=1, Q=RESET_Q (all lanes), Qbar=~RESET_Q, illegal=0. rst has priority over all other inputs.
- Per lane i, on each rising edge with rst=0:
  - E=0: Q holds, regardless of S and R.
  - E=1, S=1, R=0: Q becomes 1.
  - E=1, S=0, R=1: Q becomes 0.
  - E=1, S=0, R=0: Q holds.
  - E=1, S=1, R=1: Q follows BOTH_MODE (hold / 0 / 1), and illegal[i] is 1 for that cycle.
- illegal[i] is 0 in every other case. It is registered, so it appears one cycle after the sampled condition, aligned with the Q update.
- Latency: one clock. Inputs are sampled at edge n; Q and Qbar are valid after edge n. No combinational path from inputs to outputs.
- Qbar is always exactly ~Q. Both outputs are never equal, including during and after reset.
- Lanes are fully independent; no cross-lane interaction.
- Input changes between clock edges have no effect; only the value at the edge matters. Glitches are filtered.
- Reset asserted mid-operation overrides any pending set or reset on that edge.
- Reset released with E=S=1 on the same edge: that edge applies reset only; the set takes effect on the next edge.
- Inputs of X/Z state are not defined; the bench drives known values only.

Decomposition:
- Package gated_sr_pkg:
  - enum both_mode_e {HOLD, RESET_DOM, SET_DOM}, used as the type of BOTH_MODE.
  - Helper function next_q(q, e, s, r, mode) implementing the per-lane truth table above.
- Sub-module sr_lane_cell: one lane holding one Q flop and one illegal flop. The top generates WIDTH instances and drives Qbar as ~Q.

Test Plan:
- Reset and set: rst=1 for 2 cycles gives Q=0, Qbar=1. Then E=1, S=1, R=0 for 1 cycle gives Q=1, Qbar=0 after the edge.
- Latch hold after set: E=0, then S=0, R=1 for 2 cycles, then S=1, R=0 -> Q stays 1, Qbar stays 0 throughout.
- Reset when enabled: E=1, S=0, R=1 gives Q=0, Qbar=1. Then E=0 with S=1, R=1, then S=1, R=0 -> Q stays 0, Qbar stays 1, illegal=0.
- Forbidden input: E=1, S=1, R=1 with Q=1 gives illegal=1 for one cycle.
  - HOLD: Q=1.
  - RESET_DOM: Q=0.
  - SET_DOM: Q=1.
- Timing: S pulses high and low entirely between two edges with E=1 -> Q unchanged. Outputs change only at edges, one cycle after sampling.
- Reset priority with WIDTH=4: from Q=4'b1010, rst=1 with E=4'hF, S=4'hF -> Q=4'b0000, Qbar=4'b1111. On the next edge with rst=0 the set applies: Q=4'hF.
